// File: rtl/multicycle_ctrl_fsm.sv
// Control sequencer for the multi-cycle CPU: steps datapath through
// FETCH/DECODE/EXEC/MEM/WB with a bounded memory-ready wait.
module multicycle_ctrl_fsm #(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned CNT_W      = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] instr_op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       iord_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_src_o,
  output logic [3:0] state_o,
  output logic       instr_done_o,
  output logic       illegal_o,
  output logic       mem_err_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    WB_R     = 4'd7,
    EXEC_I   = 4'd8,
    WB_I     = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             stall;
  logic             timeout;
  logic             unused_funct;

  // funct decoding lives in the ALU control block
  assign unused_funct = ^funct_i;

  assign stall   = (state == FETCH || state == MEM_RD || state == MEM_WR) && !mem_ready_i;
  assign timeout = stall && (wait_cnt == LIMIT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      // counter only survives while stalling in the same wait state
      wait_cnt <= (stall && !timeout) ? wait_cnt + CNT_W'(1) : '0;
      case (state)
        FETCH:    if (mem_ready_i) state <= DECODE;
        DECODE: begin
          case (instr_op_i)
            OP_R:            state <= EXEC_R;
            OP_LW, OP_SW:    state <= MEM_ADDR;
            OP_ADDI, OP_SLTI: state <= EXEC_I;
            OP_BEQ, OP_BNE:  state <= BRANCH;
            OP_J:            state <= JUMP;
            default:         state <= FETCH;
          endcase
        end
        MEM_ADDR: state <= (instr_op_i == OP_LW) ? MEM_RD : MEM_WR;
        MEM_RD: begin
          if (mem_ready_i)  state <= MEM_WB;
          else if (timeout) state <= FETCH;
        end
        MEM_WR:   if (mem_ready_i || timeout) state <= FETCH;
        EXEC_R:   state <= WB_R;
        EXEC_I:   state <= WB_I;
        default:  state <= FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    iord_o       = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 2'b00;
    pc_src_o     = 2'b00;
    instr_done_o = 1'b0;
    illegal_o    = 1'b0;
    mem_err_o    = 1'b0;
    state_o      = rst_i ? 4'd0 : state;
    if (!rst_i) begin
      mem_err_o = timeout;
      case (state)
        FETCH: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = 2'b01;
          ir_write_o  = mem_ready_i;
          pc_write_o  = mem_ready_i;
        end
        DECODE: begin
          alu_src_b_o = 2'b11;
          if (!(instr_op_i inside {OP_R, OP_LW, OP_SW, OP_ADDI, OP_SLTI,
                                   OP_BEQ, OP_BNE, OP_J})) begin
            illegal_o    = 1'b1;
            instr_done_o = 1'b1;
          end
        end
        MEM_ADDR: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'b10;
        end
        MEM_RD: begin
          mem_read_o = 1'b1;
          iord_o     = 1'b1;
        end
        MEM_WB: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 1'b1;
          instr_done_o = 1'b1;
        end
        MEM_WR: begin
          mem_write_o  = 1'b1;
          iord_o       = 1'b1;
          instr_done_o = mem_ready_i;
        end
        EXEC_R: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = 2'b10;
        end
        WB_R: begin
          reg_write_o  = 1'b1;
          reg_dst_o    = 1'b1;
          instr_done_o = 1'b1;
        end
        EXEC_I: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'b10;
          alu_op_o    = (instr_op_i == OP_SLTI) ? 2'b11 : 2'b00;
        end
        WB_I: begin
          reg_write_o  = 1'b1;
          instr_done_o = 1'b1;
        end
        BRANCH: begin
          alu_src_a_o  = 1'b1;
          alu_op_o     = 2'b01;
          pc_src_o     = 2'b01;
          pc_write_o   = (instr_op_i == OP_BEQ) ? zero_i : !zero_i;
          instr_done_o = 1'b1;
        end
        JUMP: begin
          pc_src_o     = 2'b10;
          pc_write_o   = 1'b1;
          instr_done_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
